// File: rtl/trigger_acq_controller.sv
// Purpose: arms, waits for a trigger, delays, then forwards N samples with tlast, then holds off and optionally re-arms.
// Latency: captured samples appear on M_AXIS one clk after they are presented on S_AXIS.
// Backpressure: none; the sample stream has no tready, so every valid sample in the window is forwarded.
module trigger_acq_controller #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int CNT_WIDTH        = 16,
    parameter int LEN_WIDTH        = 14
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        arm,
    input  logic                        continuous,
    input  logic                        abort,
    input  logic                        trigger_in,
    input  logic [CNT_WIDTH-1:0]        delay_cycles,
    input  logic [LEN_WIDTH-1:0]        capture_len,
    input  logic [CNT_WIDTH-1:0]        holdoff_cycles,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    output logic                        M_AXIS_tlast,
    output logic                        busy,
    output logic [2:0]                  state_out,
    output logic [CNT_WIDTH-1:0]        trig_count,
    output logic [CNT_WIDTH-1:0]        trig_missed
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] cnt;       // cycles spent in the current DELAY/HOLDOFF visit
    logic [LEN_WIDTH-1:0] smp_cnt;   // samples already captured in this window
    logic [CNT_WIDTH-1:0] delay_lat;
    logic [LEN_WIDTH-1:0] len_lat;
    logic [CNT_WIDTH-1:0] holdoff_lat;
    logic [LEN_WIDTH-1:0] len_last;  // index of the final sample; length 0 behaves as 1

    logic accept;
    logic missed;
    logic relatch;
    logic fire;
    logic last;

    assign len_last  = (len_lat == '0) ? '0 : len_lat - LEN_ONE;
    assign busy      = (state != ST_IDLE);
    assign state_out = state;

    // Next-state and per-cycle event decode; abort overrides every other event.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        missed    = 1'b0;
        relatch   = 1'b0;
        fire      = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm) begin
                    state_nxt = ST_ARMED;
                    relatch   = 1'b1;
                end
            end
            ST_ARMED: begin
                if (trigger_in) begin
                    accept    = 1'b1;
                    state_nxt = (delay_lat != '0) ? ST_DELAY : ST_CAPTURE;
                end
            end
            ST_DELAY: begin
                missed = trigger_in;
                if (cnt == delay_lat - CNT_ONE) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                missed = trigger_in;
                if (S_AXIS_tvalid) begin
                    fire = 1'b1;
                    if (smp_cnt == len_last) begin
                        last = 1'b1;
                        if (holdoff_lat != '0) begin
                            state_nxt = ST_HOLDOFF;
                        end else if (continuous) begin
                            state_nxt = ST_ARMED;
                            relatch   = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            ST_HOLDOFF: begin
                missed = trigger_in;
                if (cnt == holdoff_lat - CNT_ONE) begin
                    if (continuous) begin
                        state_nxt = ST_ARMED;
                        relatch   = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            accept    = 1'b0;
            missed    = 1'b0;
            relatch   = 1'b0;
            fire      = 1'b0;
            last      = 1'b0;
        end
    end

    // State register, dwell/sample counters and configuration latch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            smp_cnt     <= '0;
            delay_lat   <= '0;
            len_lat     <= '0;
            holdoff_lat <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt == state) ? cnt + CNT_ONE : '0;
            if (state_nxt != ST_CAPTURE) begin
                smp_cnt <= '0;
            end else if (fire) begin
                smp_cnt <= smp_cnt + LEN_ONE;
            end
            if (relatch) begin
                delay_lat   <= delay_cycles;
                len_lat     <= capture_len;
                holdoff_lat <= holdoff_cycles;
            end
        end
    end

    // Registered output stream and trigger statistics.
    always_ff @(posedge clk) begin
        if (!rst) begin
            M_AXIS_tdata  <= '0;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tlast  <= 1'b0;
            trig_count    <= '0;
            trig_missed   <= '0;
        end else begin
            M_AXIS_tvalid <= fire;
            M_AXIS_tlast  <= last;
            M_AXIS_tdata  <= fire ? S_AXIS_tdata : '0;
            if (accept) begin
                trig_count <= trig_count + CNT_ONE;
            end
            if (missed && (trig_missed != '1)) begin
                trig_missed <= trig_missed + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_trigger_acq_controller.sv
// Bench for trigger_acq_controller: vector table, directed corner sequences, randomized run vs reference model.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns after the rising edge.
// The DUT has no backpressure, so the bench never stalls.
module tb_trigger_acq_controller;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int LW = 14;

    logic          clk = 1'b0;
    logic          rst, arm, continuous, abort, trigger_in;
    logic [CW-1:0] delay_cycles, holdoff_cycles;
    logic [LW-1:0] capture_len;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, busy;
    logic [2:0]    state_out;
    logic [CW-1:0] trig_count, trig_missed;

    always #5 clk = ~clk;

    trigger_acq_controller #(.AXIS_TDATA_WIDTH(DW), .CNT_WIDTH(CW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .continuous(continuous), .abort(abort),
        .trigger_in(trigger_in), .delay_cycles(delay_cycles), .capture_len(capture_len),
        .holdoff_cycles(holdoff_cycles), .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid),
        .M_AXIS_tdata(m_tdata), .M_AXIS_tvalid(m_tvalid), .M_AXIS_tlast(m_tlast),
        .busy(busy), .state_out(state_out), .trig_count(trig_count), .trig_missed(trig_missed)
    );

    int checks = 0;
    int errors = 0;
    bit quiet  = 1'b0;

    // Reference model: phase plus count-down "remaining" budgets.
    int m_st, m_dl, m_sl, m_hl, m_D, m_L, m_H, m_tc, m_tm, m_d;
    bit m_v, m_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_rearm();
        m_D  = int'(delay_cycles);
        m_L  = (capture_len == 0) ? 1 : int'(capture_len);
        m_H  = int'(holdoff_cycles);
        m_st = 1;
    endtask

    task automatic m_miss();
        if (trigger_in && m_tm < 65535) m_tm++;
    endtask

    task automatic m_end_capture();
        if (m_H > 0) begin
            m_st = 4;
            m_hl = m_H;
        end else if (continuous) m_rearm();
        else m_st = 0;
    endtask

    task automatic model_step();
        m_v = 0; m_l = 0; m_d = 0;
        if (!rst) begin
            m_st = 0; m_tc = 0; m_tm = 0; m_D = 0; m_L = 1; m_H = 0;
            return;
        end
        if (abort) begin
            m_st = 0;
            return;
        end
        case (m_st)
            0: if (arm) m_rearm();
            1: if (trigger_in) begin
                m_tc = (m_tc + 1) % 65536;
                m_sl = m_L;
                if (m_D > 0) begin
                    m_st = 2;
                    m_dl = m_D;
                end else m_st = 3;
            end
            2: begin
                m_miss();
                m_dl--;
                if (m_dl == 0) m_st = 3;
            end
            3: begin
                m_miss();
                if (s_tvalid) begin
                    m_v = 1;
                    m_d = int'(s_tdata);
                    m_sl--;
                    if (m_sl == 0) begin
                        m_l = 1;
                        m_end_capture();
                    end
                end
            end
            default: begin
                m_miss();
                m_hl--;
                if (m_hl == 0) begin
                    if (continuous) m_rearm();
                    else m_st = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        chk("tvalid", m_tvalid, m_v);
        chk("tlast", m_tlast, m_l);
        if (m_v) chk("tdata", m_tdata, m_d);
        chk("state", state_out, m_st);
        chk("busy", busy, m_st != 0);
        chk("trig_count", trig_count, m_tc);
        chk("trig_missed", trig_missed, m_tm);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        if (!quiet) compare_all();
    endtask

    task automatic do_reset();
        rst = 0; arm = 0; abort = 0; trigger_in = 0; s_tvalid = 0;
        step();
        step();
        rst = 1;
    endtask

    task automatic set_cfg(input int d, input int l, input int h, input bit c);
        delay_cycles = CW'(d); capture_len = LW'(l); holdoff_cycles = CW'(h); continuous = c;
    endtask

    typedef struct {
        logic        rst, arm, trig, tv;
        logic [15:0] d;
        int          st;
        logic        v, l;
        logic [15:0] ed;
        int          tc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n, first, lastk, tl;
        rst = 0; arm = 0; continuous = 0; abort = 0; trigger_in = 0;
        s_tvalid = 0; s_tdata = '0;
        set_cfg(0, 4, 0, 0);

        // Reset dominance, then a D=0 L=4 H=0 one-shot capture.
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hAAAA, 0, 1'b0, 1'b0, 16'h0000, 0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hAAAB, 0, 1'b0, 1'b0, 16'h0000, 0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 0, 1'b0, 1'b0, 16'h0000, 0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 1, 1'b0, 1'b0, 16'h0000, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0011, 3, 1'b0, 1'b0, 16'h0000, 1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0022, 3, 1'b1, 1'b0, 16'h0022, 1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0033, 3, 1'b1, 1'b0, 16'h0033, 1};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0044, 3, 1'b1, 1'b0, 16'h0044, 1};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0055, 0, 1'b1, 1'b1, 16'h0055, 1};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0066, 0, 1'b0, 1'b0, 16'h0000, 1};
        quiet = 1;
        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst; arm = tbl[i].arm; trigger_in = tbl[i].trig;
            s_tvalid = tbl[i].tv; s_tdata = tbl[i].d;
            step();
            chk($sformatf("tbl%0d state", i), state_out, tbl[i].st);
            chk($sformatf("tbl%0d tvalid", i), m_tvalid, tbl[i].v);
            chk($sformatf("tbl%0d tlast", i), m_tlast, tbl[i].l);
            if (tbl[i].v) chk($sformatf("tbl%0d tdata", i), m_tdata, tbl[i].ed);
            chk($sformatf("tbl%0d trig_count", i), trig_count, tbl[i].tc);
            if (!tbl[i].rst) chk($sformatf("tbl%0d missed", i), trig_missed, 0);
        end
        quiet = 0;

        // D=10, L=3, tvalid toggling: samples at t+11, t+13, t+15.
        do_reset();
        set_cfg(10, 3, 0, 0);
        arm = 1; step(); arm = 0;
        trigger_in = 1; step(); trigger_in = 0;
        n = 0; first = -1; lastk = -1;
        for (int k = 1; k <= 30; k++) begin
            s_tvalid = (k % 2 == 1);
            s_tdata  = DW'(16'h0100 + k);
            step();
            if (m_tvalid) begin
                n++;
                if (first < 0) first = k;
            end
            if (m_tlast) lastk = k;
        end
        chk("t3 sample count", n, 3);
        chk("t3 first sample edge", first, 11);
        chk("t3 tlast edge", lastk, 15);

        // Continuous, H=5, L=2, triggers every 3 cycles.
        do_reset();
        set_cfg(0, 2, 5, 1);
        arm = 1; step(); arm = 0;
        s_tvalid = 1;
        tl = 0;
        for (int k = 0; k < 60; k++) begin
            trigger_in = (k % 3 == 0);
            s_tdata = DW'($urandom);
            step();
            if (m_tlast) tl++;
        end
        trigger_in = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (m_tlast) tl++;
        end
        chk("t4 captures vs triggers", tl, m_tc);

        // Abort on the second sample of an L=8 capture.
        do_reset();
        set_cfg(0, 8, 0, 0);
        arm = 1; step(); arm = 0;
        trigger_in = 1; step(); trigger_in = 0;
        s_tvalid = 1; s_tdata = 16'h1234; step();
        chk("t5 first sample", m_tvalid, 1);
        abort = 1; s_tdata = 16'h5678; step(); abort = 0;
        chk("t5 tvalid after abort", m_tvalid, 0);
        chk("t5 tlast after abort", m_tlast, 0);
        chk("t5 busy after abort", busy, 0);
        chk("t5 state after abort", state_out, 0);

        // Saturation of trig_missed, then capture_len=0 behaves as one sample.
        do_reset();
        set_cfg(65535, 0, 0, 0);
        arm = 1; step(); arm = 0;
        trigger_in = 1; step();
        s_tvalid = 0;
        quiet = 1;
        for (int k = 0; k < 65540; k++) step();
        quiet = 0;
        chk("t6 missed saturated", trig_missed, 16'hFFFF);
        chk("t6 state capture", state_out, 3);
        trigger_in = 0; s_tvalid = 1; s_tdata = 16'hBEEF; step();
        chk("t6 single tvalid", m_tvalid, 1);
        chk("t6 single tlast", m_tlast, 1);
        chk("t6 single tdata", m_tdata, 16'hBEEF);
        chk("t6 back to idle", state_out, 0);

        // Randomized run against the reference model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 499) != 0);
            arm        = ($urandom_range(0, 3) == 0);
            continuous = $urandom_range(0, 1) != 0;
            abort      = ($urandom_range(0, 79) == 0);
            trigger_in = ($urandom_range(0, 5) == 0);
            s_tvalid   = $urandom_range(0, 1) != 0;
            s_tdata    = DW'($urandom);
            set_cfg($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 4), continuous);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
